// File: rtl/ex_muldiv_ctrl_if.sv
// Execute-stage mul/div request/response bundle between the ID/EX register and
// the iterative HI/LO sequencer.
interface ex_muldiv_ctrl_if #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 6
);
    logic               valid_i;
    logic               flush_i;
    logic [NB_OP-1:0]   opcode_i;
    logic [NB_OP-1:0]   funct_i;
    logic [NB_DATA-1:0] data_ra_i;
    logic [NB_DATA-1:0] data_rb_i;
    logic               stall_o;
    logic               busy_o;
    logic               done_o;
    logic [NB_DATA-1:0] hi_o;
    logic [NB_DATA-1:0] lo_o;
    logic [NB_DATA-1:0] hilo_rdata_o;

    modport master (
        output valid_i, flush_i, opcode_i, funct_i, data_ra_i, data_rb_i,
        input  stall_o, busy_o, done_o, hi_o, lo_o, hilo_rdata_o
    );

    modport slave (
        input  valid_i, flush_i, opcode_i, funct_i, data_ra_i, data_rb_i,
        output stall_o, busy_o, done_o, hi_o, lo_o, hilo_rdata_o
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; serves MFHI/MFLO/MTHI/MTLO.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU are ignored.
module ex_muldiv_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 6
) (
    input logic             clk_i,
    input logic             rst_n_i,
    ex_muldiv_ctrl_if.slave bus
);
    localparam int CW = $clog2(NB_DATA);
    localparam logic [NB_OP-1:0] F_MFHI  = NB_OP'(6'h10);
    localparam logic [NB_OP-1:0] F_MTHI  = NB_OP'(6'h11);
    localparam logic [NB_OP-1:0] F_MFLO  = NB_OP'(6'h12);
    localparam logic [NB_OP-1:0] F_MTLO  = NB_OP'(6'h13);
    localparam logic [NB_OP-1:0] F_MULT  = NB_OP'(6'h18);
    localparam logic [NB_OP-1:0] F_MULTU = NB_OP'(6'h19);
`ifdef MULDIV_DIV_EN
    localparam logic [NB_OP-1:0] F_DIV   = NB_OP'(6'h1A);
    localparam logic [NB_OP-1:0] F_DIVU  = NB_OP'(6'h1B);
`endif

    typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

    state_t             state;
    logic               busy_q, done_q, neg_q;
    logic [CW-1:0]      cnt_q;
    logic [NB_DATA-1:0] hi_q, lo_q, acc_hi, acc_lo, opb_q;

    logic               is_special, is_mul, is_div_op, md_op, is_mt, is_mf, hilo_op;
    logic               op_signed, sign_a, sign_b;
    logic [NB_DATA-1:0] abs_a, abs_b, rdata;
    logic [NB_DATA:0]   mul_sum;
    logic [2*NB_DATA-1:0] prod_fix;

    always_comb begin
        is_special = bus.valid_i && (bus.opcode_i == '0);
        is_mul     = is_special && (bus.funct_i == F_MULT || bus.funct_i == F_MULTU);
        op_signed  = (bus.funct_i == F_MULT);
`ifdef MULDIV_DIV_EN
        is_div_op  = is_special && (bus.funct_i == F_DIV || bus.funct_i == F_DIVU);
        op_signed  = op_signed || (bus.funct_i == F_DIV);
`else
        is_div_op  = 1'b0;
`endif
        md_op      = is_mul || is_div_op;
        is_mt      = is_special && (bus.funct_i == F_MTHI || bus.funct_i == F_MTLO);
        is_mf      = is_special && (bus.funct_i == F_MFHI || bus.funct_i == F_MFLO);
        hilo_op    = md_op || is_mt || is_mf;
        sign_a     = op_signed && bus.data_ra_i[NB_DATA-1];
        sign_b     = op_signed && bus.data_rb_i[NB_DATA-1];
        abs_a      = sign_a ? -bus.data_ra_i : bus.data_ra_i;
        abs_b      = sign_b ? -bus.data_rb_i : bus.data_rb_i;
        rdata      = '0;
        if (is_special && bus.funct_i == F_MFHI) rdata = hi_q;
        if (is_special && bus.funct_i == F_MFLO) rdata = lo_q;
    end

    // rs sits in the low accumulator half for both kinds: multiplier for MUL
    // (product is commutative), dividend for DIV; rt is the add/subtract operand.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

`ifdef MULDIV_DIV_EN
    logic                 is_div_q, neg_rem_q, div0_q;
    logic [NB_DATA:0]     div_shift;
    logic [NB_DATA+1:0]   div_diff;
    logic                 div_ge;
    logic [NB_DATA-1:0]   quot_fix, rem_fix;

    assign div_shift = {acc_hi, acc_lo[NB_DATA-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b0, opb_q};
    assign div_ge    = ~div_diff[NB_DATA+1];
    // With a zero divisor every trial succeeds, so the remainder ends up as |rs|;
    // restoring its sign reproduces the raw dividend for HI without extra storage.
    assign quot_fix  = div0_q ? '1 : (neg_q ? -acc_lo : acc_lo);
    assign rem_fix   = neg_rem_q ? -acc_hi : acc_hi;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb_q  <= '0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (md_op && !bus.flush_i) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        cnt_q  <= CW'(NB_DATA-1);
                        acc_hi <= '0;
                        acc_lo <= abs_a;
                        opb_q  <= abs_b;
                        neg_q  <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
                        is_div_q  <= is_div_op;
                        neg_rem_q <= sign_a;
                        div0_q    <= (bus.data_rb_i == '0);
`endif
                    end else if (is_mt && !bus.flush_i) begin
                        if (bus.funct_i == F_MTHI) hi_q <= bus.data_ra_i;
                        else                       lo_q <= bus.data_ra_i;
                    end
                end
                RUN: begin
                    if (bus.flush_i) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (is_div_q) begin
                            acc_hi <= div_ge ? div_diff[NB_DATA-1:0] : div_shift[NB_DATA-1:0];
                            acc_lo <= {acc_lo[NB_DATA-2:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[NB_DATA:1];
                            acc_lo <= {mul_sum[0], acc_lo[NB_DATA-1:1]};
                        end
`else
                        acc_hi <= mul_sum[NB_DATA:1];
                        acc_lo <= {mul_sum[0], acc_lo[NB_DATA-1:1]};
`endif
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) state <= SIGN;
                    end
                end
                SIGN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (!bus.flush_i) begin
                        done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            hi_q <= prod_fix[2*NB_DATA-1:NB_DATA];
                            lo_q <= prod_fix[NB_DATA-1:0];
                        end
`else
                        hi_q <= prod_fix[2*NB_DATA-1:NB_DATA];
                        lo_q <= prod_fix[NB_DATA-1:0];
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall_o      = hilo_op && busy_q && !bus.flush_i;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.hi_o         = hi_q;
    assign bus.lo_o         = lo_q;
    assign bus.hilo_rdata_o = rdata;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: arithmetic reference model compared every cycle,
// plus literal HI/LO/timing expectations per vector.
module tb_ex_muldiv_ctrl;
    localparam int NB_DATA = 32;
    localparam int NB_OP   = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ex_muldiv_ctrl_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus();
    ex_muldiv_ctrl #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_md(logic v, logic [5:0] op, logic [5:0] f);
        logic r;
        r = v && op == 6'h00 && (f == 6'h18 || f == 6'h19);
`ifdef MULDIV_DIV_EN
        r = r || (v && op == 6'h00 && (f == 6'h1A || f == 6'h1B));
`endif
        return r;
    endfunction

    function automatic logic is_hilo(logic v, logic [5:0] op, logic [5:0] f);
        return is_md(v, op, f) || (v && op == 6'h00 && f >= 6'h10 && f <= 6'h13);
    endfunction

    function automatic logic [63:0] model_result(logic [5:0] f, logic [31:0] a, logic [31:0] b);
        logic [63:0] r;
        logic signed [31:0] sa, sb, q, rm;
        sa = a; sb = b;
        r  = '0;
        case (f)
            6'h18: r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            6'h19: r = {32'h0, a} * {32'h0, b};
            6'h1A: begin
                if (b == 0)                                   r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm, q};
                end
            end
            6'h1B: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_hi <= '0; m_lo <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (bus.flush_i) m_busy <= 1'b0;
                else if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_hi <= p_hi; m_lo <= p_lo;
                end else m_left <= m_left - 1;
            end else if (is_md(bus.valid_i, bus.opcode_i, bus.funct_i) && !bus.flush_i) begin
                {p_hi, p_lo} <= model_result(bus.funct_i, bus.data_ra_i, bus.data_rb_i);
                m_busy <= 1'b1;
                m_left <= 33;
            end else if (bus.valid_i && bus.opcode_i == 6'h00 && !bus.flush_i) begin
                if (bus.funct_i == 6'h11) m_hi <= bus.data_ra_i;
                if (bus.funct_i == 6'h13) m_lo <= bus.data_ra_i;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_stall;
            logic [31:0] e_rd;
            e_stall = is_hilo(bus.valid_i, bus.opcode_i, bus.funct_i) && m_busy && !bus.flush_i;
            e_rd    = '0;
            if (bus.valid_i && bus.opcode_i == 6'h00 && bus.funct_i == 6'h10) e_rd = m_hi;
            if (bus.valid_i && bus.opcode_i == 6'h00 && bus.funct_i == 6'h12) e_rd = m_lo;
            check("cyc_stall", {31'b0, bus.stall_o}, {31'b0, e_stall});
            check("cyc_busy",  {31'b0, bus.busy_o},  {31'b0, m_busy});
            check("cyc_done",  {31'b0, bus.done_o},  {31'b0, m_done});
            check("cyc_hi",    bus.hi_o, m_hi);
            check("cyc_lo",    bus.lo_o, m_lo);
            check("cyc_rdata", bus.hilo_rdata_o, e_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i = 1'b1; bus.opcode_i = 6'h00; bus.funct_i = f;
        bus.data_ra_i = a; bus.data_rb_i = b;
    endtask

    task automatic idle_in();
        bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.opcode_i = 6'h00;
        bus.funct_i = 6'h00; bus.data_ra_i = '0; bus.data_rb_i = '0;
    endtask

    // Holds the instruction until it is not stalled, then lets it cross one edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int k;
        drive(f, a, b);
        for (k = 0; k < 100; k++) begin
            #1;
            if (!bus.stall_o) break;
            @(posedge clk); #1;
        end
        if (k == 100) begin
            n_vec++; n_err++;
            $display("FAIL issue_timeout: funct %h still stalled after %0d cycles", f, k);
        end
        @(posedge clk); #1;
        idle_in();
    endtask

    task automatic wait_done(input string name, input logic [31:0] ehi, input logic [31:0] elo);
        int nb, nd;
        nb = 0; nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.busy_o) nb++;
            if (bus.done_o) nd++;
            tick();
        end
        check({name, "_busy_cycles"}, nb, 33);
        check({name, "_done_pulses"}, nd, 1);
        check({name, "_hi"}, bus.hi_o, ehi);
        check({name, "_lo"}, bus.lo_o, elo);
    endtask

    initial begin
        int nst, nd;
        idle_in();
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        check("rst_hi", bus.hi_o, 32'h0);
        check("rst_lo", bus.lo_o, 32'h0);
        check("rst_busy", {31'b0, bus.busy_o}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // model pins: hand-computed results
        check("model_mult", model_result(6'h18, 32'd7, 32'hFFFF_FFFD) >> 32, 32'hFFFF_FFFF);
        check("model_divu", model_result(6'h1B, 32'd100, 32'd7) & 64'hFFFF_FFFF, 32'd14);

        issue(6'h18, 32'd7, 32'hFFFF_FFFD);
        wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        issue(6'h18, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_minmin", 32'h4000_0000, 32'h0000_0000);
        issue(6'h18, 32'hFFFF_FFFF, 32'd1);
        wait_done("mult_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

`ifdef MULDIV_DIV_EN
        issue(6'h1B, 32'd100, 32'd7);
        wait_done("divu", 32'd2, 32'd14);
        issue(6'h1A, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(6'h1A, 32'd5, 32'd0);
        wait_done("div_zero", 32'd5, 32'hFFFF_FFFF);
        issue(6'h1A, 32'hFFFF_FFF0, 32'd0);
        wait_done("div_zero_neg", 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 32'h0, 32'h8000_0000);
`endif

        // MFLO three cycles after MULT; ADD while busy must not stall
        issue(6'h18, 32'd3, 32'd4);
        drive(6'h20, 32'd1, 32'd2);
        #1 check("add_nostall", {31'b0, bus.stall_o}, 32'h0);
        tick();
        idle_in();
        tick();
        drive(6'h12, 32'd0, 32'd0);
        nst = 0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (!bus.stall_o) break;
            nst++;
            @(posedge clk);
        end
        check("mflo_stall_cycles", nst, 31);
        check("mflo_busy_low", {31'b0, bus.busy_o}, 32'h0);
        check("mflo_rdata", bus.hilo_rdata_o, 32'h0000_000C);
        tick();
        idle_in();
        tick();

        // back-to-back: second op waits through SIGN and is taken in IDLE
        issue(6'h18, 32'd2, 32'd3);
        issue(6'h19, 32'd10, 32'd10);
        wait_done("b2b", 32'd0, 32'd100);

        // flush mid-run leaves HI/LO alone
        issue(6'h11, 32'h0000_00AA, 32'd0);
`ifdef MULDIV_DIV_EN
        issue(6'h1A, 32'd9, 32'd3);
`else
        issue(6'h18, 32'd9, 32'd3);
`endif
        repeat (9) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("flush_busy", {31'b0, bus.busy_o}, 32'h0);
        check("flush_hi", bus.hi_o, 32'h0000_00AA);
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done_o) nd++;
            tick();
        end
        check("flush_no_done", nd, 0);

        // flush and accept together: nothing accepted
        drive(6'h18, 32'd5, 32'd5);
        bus.flush_i = 1'b1;
        tick();
        idle_in();
        check("flush_accept_busy", {31'b0, bus.busy_o}, 32'h0);

        // reset mid-run clears everything
        issue(6'h13, 32'h0000_0055, 32'd0);
        issue(6'h18, 32'd5, 32'd6);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstmid_hi", bus.hi_o, 32'h0);
        check("rstmid_lo", bus.lo_o, 32'h0);
        check("rstmid_busy", {31'b0, bus.busy_o}, 32'h0);
        check("rstmid_done", {31'b0, bus.done_o}, 32'h0);
        check("rstmid_stall", {31'b0, bus.stall_o}, 32'h0);
        tick();

`ifndef MULDIV_DIV_EN
        // without the divider DIV is a no-op for this block
        issue(6'h11, 32'h0000_0011, 32'd0);
        issue(6'h13, 32'h0000_0022, 32'd0);
        drive(6'h1A, 32'd8, 32'd2);
        #1 check("nodiv_stall", {31'b0, bus.stall_o}, 32'h0);
        tick();
        idle_in();
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.busy_o || bus.done_o) nd++;
            tick();
        end
        check("nodiv_busy_done", nd, 0);
        check("nodiv_hi", bus.hi_o, 32'h0000_0011);
        check("nodiv_lo", bus.lo_o, 32'h0000_0022);
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
